heading_stabilizer: RTL and testbench

//  Sits directly downstream of the 16-direction heading calculation stage.
//  - Filters out heading jitter: a new heading is accepted only after CONFIRM_COUNT identical consecutive samples.
//  - Converts each confirmed heading to a 4-bit sector index.
//  - Converts each confirmed heading to 3 BCD digits for the 7-segment display driver.
//  - BCD conversion is a sequential double-dabble.

---
 rtl/heading_stabilizer.sv | 158 +++++++++++++++
 tb/tb_heading_stabilizer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/heading_stabilizer.sv
// Debounces the 16-direction heading stream, commits stable values and converts
// each committed heading to a compass sector and three BCD digits.
module heading_stabilizer #(
    parameter int unsigned CONFIRM_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] heading_in,
    input  logic       heading_valid,
    output logic [8:0] heading_out,
    output logic [3:0] sector,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       out_valid,
    output logic       busy,
    output logic       range_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [8:0]  last_commit;
    logic [8:0]  candidate;
    logic [8:0]  commit_val;
    logic [8:0]  conv_val;
    logic [3:0]  count;
    logic        pending;
    logic [20:0] sreg;      // {hundreds, tens, ones, binary}
    logic [3:0]  bit_cnt;

    logic        legal_strobe;
    logic        commit_now;
    logic [3:0]  next_count;
    logic [8:0]  next_cand;

    // Nearest 22.5-degree sector as a ladder of thresholds on 2h+22 (multiples of 45).
    function automatic logic [3:0] sector_of(input logic [8:0] h);
        logic [10:0] twice;
        logic [3:0]  s;
        twice = {1'b0, h, 1'b0} + 11'd22;
        s = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (twice >= 11'(45 * k)) s = 4'(k);
        end
        if (twice >= 11'd720) s = '0;
        return s;
    endfunction

    function automatic logic [20:0] dabble(input logic [20:0] s);
        logic [20:0] t;
        t = s;
        for (int unsigned i = 0; i < 3; i++) begin
            if (t[9 + 4*i +: 4] >= 4'd5) t[9 + 4*i +: 4] = t[9 + 4*i +: 4] + 4'd3;
        end
        return {t[19:0], 1'b0};
    endfunction

    always_comb begin
        legal_strobe = heading_valid && (heading_in <= 9'd359);
        commit_now   = 1'b0;
        next_count   = count;
        next_cand    = candidate;
        if (legal_strobe) begin
            if (heading_in == last_commit) begin
                next_count = '0;
            end else if (heading_in == candidate && count != '0) begin
                next_count = count + 4'd1;
            end else begin
                next_cand  = heading_in;
                next_count = 4'd1;
            end
            if (next_count == 4'(CONFIRM_COUNT)) begin
                commit_now = 1'b1;
                next_count = '0;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_commit  <= '0;
            candidate    <= '0;
            commit_val   <= '0;
            conv_val     <= '0;
            count        <= '0;
            pending      <= 1'b0;
            sreg         <= '0;
            bit_cnt      <= '0;
            heading_out  <= '0;
            sector       <= '0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
            out_valid    <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (heading_valid && !legal_strobe) range_err <= 1'b1;
            if (legal_strobe) begin
                candidate <= next_cand;
                count     <= next_count;
            end
            if (commit_now) begin
                commit_val  <= heading_in;
                last_commit <= heading_in;
            end

            case (state)
                IDLE: begin
                    // A fresh commit supersedes one left pending from the DONE exit edge.
                    if (commit_now) begin
                        sreg     <= {12'd0, heading_in};
                        conv_val <= heading_in;
                        bit_cnt  <= '0;
                        pending  <= 1'b0;
                        state    <= SHIFT;
                    end else if (pending) begin
                        sreg     <= {12'd0, commit_val};
                        conv_val <= commit_val;
                        bit_cnt  <= '0;
                        pending  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg    <= dabble(sreg);
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) state <= DONE;
                    if (commit_now) pending <= 1'b1;
                end
                DONE: begin
                    heading_out  <= conv_val;
                    sector       <= sector_of(conv_val);
                    bcd_hundreds <= sreg[20:17];
                    bcd_tens     <= sreg[16:13];
                    bcd_ones     <= sreg[12:9];
                    out_valid    <= 1'b1;
                    // Reload uses the pre-edge commit_val; a commit on this edge stays pending.
                    pending      <= commit_now;
                    if (pending) begin
                        sreg     <= {12'd0, commit_val};
                        conv_val <= commit_val;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end else begin
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heading_stabilizer.sv
// Scoreboard bench for heading_stabilizer: two instances, CONFIRM_COUNT=4 (a) and 1 (b).
module tb_heading_stabilizer;

    typedef struct {
        int h;
        int sec;
        int hun;
        int ten;
        int one;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] heading_in = '0;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;

    logic [8:0] ho_a, ho_b;
    logic [3:0] sec_a, sec_b, hun_a, hun_b, ten_a, ten_b, one_a, one_b;
    logic       ov_a, ov_b, busy_a, busy_b, rerr_a, rerr_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_edge = 0;
    exp_t qa[$];
    exp_t qb[$];

    heading_stabilizer #(.CONFIRM_COUNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .heading_in(heading_in), .heading_valid(valid_a),
        .heading_out(ho_a), .sector(sec_a), .bcd_hundreds(hun_a), .bcd_tens(ten_a),
        .bcd_ones(one_a), .out_valid(ov_a), .busy(busy_a), .range_err(rerr_a)
    );

    heading_stabilizer #(.CONFIRM_COUNT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .heading_in(heading_in), .heading_valid(valid_b),
        .heading_out(ho_b), .sector(sec_b), .bcd_hundreds(hun_b), .bcd_tens(ten_b),
        .bcd_ones(one_b), .out_valid(ov_b), .busy(busy_b), .range_err(rerr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t make_exp(input int h, input int at);
        exp_t e;
        e.h   = h;
        e.sec = ((2 * h + 22) / 45) % 16;
        e.hun = h / 100;
        e.ten = (h / 10) % 10;
        e.one = h % 10;
        e.cyc = at;
        return e;
    endfunction

    // Pops an expectation per out_valid pulse; a pulse with nothing queued is a failure.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov_a) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse_a: got heading %0d at cycle %0d, required no pulse", ho_a, cyc);
            end else begin
                e = qa.pop_front();
                if ({ho_a, sec_a, hun_a, ten_a, one_a} !== {9'(e.h), 4'(e.sec), 4'(e.hun), 4'(e.ten), 4'(e.one)} || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result_a: got h=%0d sec=%0d bcd=%0d%0d%0d cyc=%0d, required h=%0d sec=%0d bcd=%0d%0d%0d cyc=%0d",
                             ho_a, sec_a, hun_a, ten_a, one_a, cyc, e.h, e.sec, e.hun, e.ten, e.one, e.cyc);
                end
            end
        end
        if (rst_n && ov_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse_b: got heading %0d at cycle %0d, required no pulse", ho_b, cyc);
            end else begin
                e = qb.pop_front();
                if ({ho_b, sec_b, hun_b, ten_b, one_b} !== {9'(e.h), 4'(e.sec), 4'(e.hun), 4'(e.ten), 4'(e.one)} || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result_b: got h=%0d sec=%0d bcd=%0d%0d%0d cyc=%0d, required h=%0d sec=%0d bcd=%0d%0d%0d cyc=%0d",
                             ho_b, sec_b, hun_b, ten_b, one_b, cyc, e.h, e.sec, e.hun, e.ten, e.one, e.cyc);
                end
            end
        end
    end

    task automatic strobe(input bit to_b, input int h);
        @(negedge clk);
        heading_in = 9'(h);
        valid_a = !to_b;
        valid_b = to_b;
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 40;
        while ((qa.size() != 0 || qb.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d/%0d outstanding, required 0/0", name, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ho_a, sec_a, hun_a, ten_a, one_a, ov_a, busy_a, rerr_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got %h, required 0", {ho_a, sec_a, hun_a, ten_a, one_a, ov_a, busy_a, rerr_a});
        end
        checks++;
        if ({ho_b, sec_b, hun_b, ten_b, one_b, ov_b, busy_b, rerr_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got %h, required 0", {ho_b, sec_b, hun_b, ten_b, one_b, ov_b, busy_b, rerr_b});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_confirm;
        for (int i = 0; i < 3; i++) strobe(0, 90);
        idle(15);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL confirm_early_busy: got %b, required 0", busy_a);
        end
        strobe(0, 90);
        qa.push_back(make_exp(90, last_edge + 10));
        idle(1);
        drain("confirm");
    endtask

    task automatic test_filter;
        int seq[7] = '{180, 180, 270, 180, 180, 180, 180};
        for (int i = 0; i < 6; i++) strobe(0, seq[i]);
        idle(15);
        strobe(0, seq[6]);
        qa.push_back(make_exp(180, last_edge + 10));
        idle(1);
        drain("filter");
    endtask

    task automatic test_range;
        strobe(0, 359);
        strobe(0, 359);
        strobe(0, 400);
        idle(2);
        checks++;
        if ({rerr_a, ho_a, busy_a} !== {1'b1, 9'd180, 1'b0}) begin
            errors++;
            $display("FAIL range_flag: got err=%b h=%0d busy=%b, required err=1 h=180 busy=0", rerr_a, ho_a, busy_a);
        end
        checks++;
        if (rerr_b !== 1'b0) begin
            errors++;
            $display("FAIL range_other: got %b, required 0", rerr_b);
        end
        strobe(0, 359);
        strobe(0, 359);
        qa.push_back(make_exp(359, last_edge + 10));
        idle(1);
        drain("range");
        checks++;
        if (rerr_a !== 1'b1) begin
            errors++;
            $display("FAIL range_sticky: got %b, required 1", rerr_a);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        strobe(1, 22);
        first = last_edge;
        qb.push_back(make_exp(22, first + 10));
        strobe(1, 45);
        strobe(1, 338);
        qb.push_back(make_exp(338, first + 20));
        idle(1);
        drain("back_to_back");
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 4; i++) strobe(0, 248);
        idle(0);
        // Negedge after E1; E5 is four posedges later.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ho_a, sec_a, hun_a, ten_a, one_a, ov_a, busy_a, rerr_a} !== '0) begin
            errors++;
            $display("FAIL midflight_reset: got %h, required 0", {ho_a, sec_a, hun_a, ten_a, one_a, ov_a, busy_a, rerr_a});
        end
        rst_n = 1'b1;
        idle(15);
        checks++;
        if ({ho_a, busy_a} !== '0) begin
            errors++;
            $display("FAIL midflight_dropped: got h=%0d busy=%b, required 0/0", ho_a, busy_a);
        end
        for (int i = 0; i < 4; i++) strobe(0, 248);
        qa.push_back(make_exp(248, last_edge + 10));
        idle(1);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_confirm();
        test_filter();
        test_range();
        test_back_to_back();
        test_reset_midflight();
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
